// File: rtl/spike_aer_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : spike_aer_encoder_if
// Purpose  : valid/ready address-event stream; aer_ts exists only when
//            AER_TIMESTAMP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface spike_aer_encoder_if #(
    parameter int ADDR_W   = 3
`ifdef AER_TIMESTAMP_EN
    ,
    parameter int TS_WIDTH = 16
`endif
);
    logic              aer_valid;
    logic              aer_ready;
    logic [ADDR_W-1:0] aer_addr;
`ifdef AER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] aer_ts;

    modport master (output aer_valid, output aer_addr, output aer_ts, input aer_ready);
    modport slave  (input aer_valid, input aer_addr, input aer_ts, output aer_ready);
`else
    modport master (output aer_valid, output aer_addr, input aer_ready);
    modport slave  (input aer_valid, input aer_addr, output aer_ready);
`endif
endinterface
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_aer_encoder
// Purpose  : Round-robin AER encoder for a neuron spike bank with an output
//            event FIFO. Define AER_TIMESTAMP_EN to timestamp each event.
// Revision : 1.0  initial release
// ============================================================================
module spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int ADDR_W     = $clog2(N_NEURONS),
    parameter int FIFO_DEPTH = 4
`ifdef AER_TIMESTAMP_EN
    ,
    parameter int TS_WIDTH   = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_NEURONS-1:0] spike_in,
    spike_aer_encoder_if.master  aer,
    output logic [7:0]           drop_count,
    output logic [N_NEURONS-1:0] pending
);
    localparam int                c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(N_NEURONS - 1);

    logic [N_NEURONS-1:0] r_pending;
    logic [ADDR_W-1:0]    r_rr_ptr;
    logic [ADDR_W-1:0]    r_mem_addr [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [7:0]           r_drop_count;

    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_hi_found;
    logic                 w_lo_found;
    logic [ADDR_W-1:0]    w_hi_idx;
    logic [ADDR_W-1:0]    w_lo_idx;
    logic                 w_grant_valid;
    logic [ADDR_W-1:0]    w_grant_idx;
    logic [N_NEURONS-1:0] w_grant;
    logic [N_NEURONS-1:0] w_coalesce;
    logic [8:0]           w_drop_inc;
    logic [9:0]           w_drop_sum;

    assign w_pop     = aer.aer_valid & aer.aer_ready;
    assign w_push_ok = (r_count < c_DEPTH) | w_pop;

    // Two searches in one pass: lowest pending index at/after the pointer,
    // and lowest pending index overall (used when the search must wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = ADDR_W'(i);
                if (ADDR_W'(i) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ADDR_W'(i);
                end
            end
        end
    end

    assign w_grant_valid = (w_hi_found | w_lo_found) & w_push_ok;
    assign w_grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

    always_comb begin
        w_grant = '0;
        if (w_grant_valid) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // A re-spike on the granted neuron becomes a fresh pending event, not a loss.
    assign w_coalesce = spike_in & r_pending & ~w_grant;

    always_comb begin
        w_drop_inc = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            w_drop_inc = w_drop_inc + 9'(w_coalesce[i]);
        end
        w_drop_sum = {2'b00, r_drop_count} + {1'b0, w_drop_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= '0;
            r_rr_ptr     <= '0;
            r_drop_count <= '0;
        end else begin
            r_pending    <= (r_pending & ~w_grant) | spike_in;
            r_drop_count <= (w_drop_sum > 10'd255) ? 8'hFF : w_drop_sum[7:0];
            if (w_grant_valid) begin
                r_rr_ptr <= (w_grant_idx == c_LAST) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem_addr[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_grant_valid) begin
                r_mem_addr[r_wr_ptr] <= w_grant_idx;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_grant_valid, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts;
    logic [TS_WIDTH-1:0] r_mem_ts [FIFO_DEPTH];

    // Events carry the counter value seen at their push edge (pre-increment).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem_ts[k] <= '0;
            end
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_grant_valid) begin
                r_mem_ts[r_wr_ptr] <= r_ts;
            end
        end
    end

    assign aer.aer_ts = r_mem_ts[r_rd_ptr];
`endif

    assign aer.aer_valid = (r_count != '0);
    assign aer.aer_addr  = r_mem_addr[r_rd_ptr];
    assign drop_count    = r_drop_count;
    assign pending       = r_pending;

endmodule
`default_nettype wire
